// File: rtl/vga_mem_arbiter_if.sv
// vga_mem_arbiter_if
// Bus bundle between the pipeline MEM stage, the VGA scanout fetcher, the shared
// single-port data/frame RAM and the arbiter.
//   CPU side : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_stall, cpu_rvalid, cpu_rdata
//   VGA side : vga_req, vga_addr                    -> vga_gnt, vga_rvalid, vga_rdata
//   RAM side : mem_en, mem_we, mem_addr, mem_wdata  <- mem_rdata
// Modports:
//   slave  - the arbiter's view (drives grants, stalls, read data and RAM controls)
//   master - the requesters'/RAM model's view (drives requests and mem_rdata)
interface vga_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vga_req, vga_addr,
        input  mem_rdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        output vga_gnt, vga_rvalid, vga_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vga_req, vga_addr,
        output mem_rdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        input  vga_gnt, vga_rvalid, vga_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter
// Shares one single-port synchronous RAM between the pipeline MEM stage and the
// VGA scanout fetcher. VGA wins by default so pixel deadlines are met; after
// STARVE_MAX consecutive VGA grants with a CPU request waiting, the CPU is forced
// through for one access. The pipeline is held through cpu_stall.
// Ports:
//   clk    - system clock, everything on posedge
//   reset  - synchronous, active-low
//   bus    - vga_mem_arbiter_if.slave (CPU, VGA and RAM signal groups)
//   cpu_wait_cnt / vga_acc_cnt - 16-bit saturating statistics, only present
//            when the macro ARB_STATS_EN is defined
// Timing: request accepted at edge E -> RAM controls registered in cycle E+1 ->
// read data and a one-cycle rvalid pulse in cycle E+2. Stores give no rvalid.
module vga_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    vga_mem_arbiter_if.slave    bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]         cpu_wait_cnt,
    output logic [15:0]         vga_acc_cnt
`endif
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_TOP  = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);

    typedef enum logic {
        VGA_PRI   = 1'b0,
        CPU_FORCE = 1'b1
    } arbState_t;

    arbState_t         stateReg, stateNext;
    logic [CNT_W-1:0]  starveReg, starveNext;
    logic              vgaGnt, cpuStall, vgaAcc, cpuAcc;

    logic              memEnReg, memWeReg, tagReg;   // tagReg=1: access belongs to CPU
    logic [ADDR_W-1:0] memAddrReg;
    logic [DATA_W-1:0] memWdataReg;
    logic              cpuRvalidReg, vgaRvalidReg;

    // Grant/stall decode plus next-state. Grants are forced low while reset is
    // held so nothing looks accepted during reset.
    always_comb begin
        vgaGnt     = 1'b0;
        cpuStall   = 1'b0;
        stateNext  = stateReg;
        starveNext = starveReg;

        if (reset) begin
            case (stateReg)
                VGA_PRI: begin
                    vgaGnt   = bus.vga_req;
                    cpuStall = bus.cpu_req & bus.vga_req;
                end
                CPU_FORCE: begin
                    vgaGnt   = bus.vga_req & ~bus.cpu_req;
                    cpuStall = 1'b0;
                end
                default: ;
            endcase
        end

        vgaAcc = bus.vga_req & vgaGnt;
        cpuAcc = bus.cpu_req & ~cpuStall & reset;

        // Only VGA wins that actually starve a waiting CPU are counted.
        if (!bus.cpu_req || cpuAcc) begin
            starveNext = '0;
        end else if (vgaAcc && starveReg != STARVE_TOP) begin
            starveNext = starveReg + 1'b1;
        end

        case (stateReg)
            VGA_PRI: begin
                if (vgaAcc && bus.cpu_req && starveReg == STARVE_LAST) begin
                    stateNext = CPU_FORCE;
                end
            end
            CPU_FORCE: begin
                if (cpuAcc || !bus.cpu_req) begin
                    stateNext = VGA_PRI;
                end
            end
            default: stateNext = VGA_PRI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg  <= VGA_PRI;
            starveReg <= '0;
        end else begin
            stateReg  <= stateNext;
            starveReg <= starveNext;
        end
    end

    // RAM request stage and read-return stage. Clearing memEnReg on reset is
    // what drops an in-flight read, so no rvalid appears after release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            memEnReg     <= 1'b0;
            memWeReg     <= 1'b0;
            memAddrReg   <= '0;
            memWdataReg  <= '0;
            tagReg       <= 1'b0;
            cpuRvalidReg <= 1'b0;
            vgaRvalidReg <= 1'b0;
        end else begin
            memEnReg <= cpuAcc | vgaAcc;
            memWeReg <= cpuAcc & bus.cpu_we;
            if (cpuAcc) begin
                memAddrReg  <= bus.cpu_addr;
                memWdataReg <= bus.cpu_wdata;
                tagReg      <= 1'b1;
            end else if (vgaAcc) begin
                memAddrReg  <= bus.vga_addr;
                tagReg      <= 1'b0;
            end
            cpuRvalidReg <= memEnReg & ~memWeReg & tagReg;
            vgaRvalidReg <= memEnReg & ~memWeReg & ~tagReg;
        end
    end

    assign bus.vga_gnt    = vgaGnt;
    assign bus.cpu_stall  = cpuStall;
    assign bus.mem_en     = memEnReg;
    assign bus.mem_we     = memWeReg;
    assign bus.mem_addr   = memAddrReg;
    assign bus.mem_wdata  = memWdataReg;
    assign bus.cpu_rvalid = cpuRvalidReg;
    assign bus.vga_rvalid = vgaRvalidReg;
    // Both requesters see the RAM output; rvalid says whose it is.
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.vga_rdata  = bus.mem_rdata;

`ifdef ARB_STATS_EN
    logic [15:0] cpuWaitReg, vgaAccReg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cpuWaitReg <= '0;
            vgaAccReg  <= '0;
        end else begin
            if (cpuStall && cpuWaitReg != 16'hFFFF) begin
                cpuWaitReg <= cpuWaitReg + 16'd1;
            end
            if (vgaAcc && vgaAccReg != 16'hFFFF) begin
                vgaAccReg <= vgaAccReg + 16'd1;
            end
        end
    end

    assign cpu_wait_cnt = cpuWaitReg;
    assign vga_acc_cnt  = vgaAccReg;
`endif
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter
// Directed bench for vga_mem_arbiter with a small write-first RAM model.
// Inputs change 1 time unit after posedge; outputs are checked at least 1 unit
// after the edge that produced them. Build with ARB_STATS_EN to add the
// statistics scenario.
`timescale 1ns/1ps
module tb_vga_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    vga_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

`ifdef ARB_STATS_EN
    logic [15:0] cpuWaitCnt, vgaAccCnt;
    vga_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .cpu_wait_cnt(cpuWaitCnt), .vga_acc_cnt(vgaAccCnt)
    );
`else
    vga_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    // Single-port synchronous RAM, write-first, 1-cycle read latency.
    logic [31:0] ram [0:1023];
    logic [31:0] ramQ;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr[9:0]] <= bus.mem_wdata;
                ramQ <= bus.mem_wdata;
            end else begin
                ramQ <= ram[bus.mem_addr[9:0]];
            end
        end
    end
    assign bus.mem_rdata = ramQ;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cpu_req = 1'b0;
        bus.vga_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0001;
        bus.cpu_wdata = 32'h0;
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0ABC;
        for (int i = 0; i < 2; i++) begin
            step();
            testsRun++;
            if ({bus.mem_en, bus.mem_we, bus.cpu_rvalid, bus.vga_rvalid,
                 bus.vga_gnt, bus.cpu_stall} !== 6'b0 ||
                bus.mem_addr !== 16'h0 || bus.mem_wdata !== 32'h0) begin
                testsFailed++;
                $display("FAIL reset_outputs cyc%0d: en=%0b we=%0b rv=%0b%0b gnt=%0b stall=%0b addr=%h wdata=%h required all 0",
                         i, bus.mem_en, bus.mem_we, bus.cpu_rvalid, bus.vga_rvalid,
                         bus.vga_gnt, bus.cpu_stall, bus.mem_addr, bus.mem_wdata);
            end
        end
        reset = 1'b1;
        #1;
        testsRun++;
        if (bus.vga_gnt !== 1'b1 || bus.cpu_stall !== 1'b1) begin
            testsFailed++;
            $display("FAIL reset_first_grant: gnt=%0b stall=%0b required gnt=1 stall=1",
                     bus.vga_gnt, bus.cpu_stall);
        end
        step();
        idle();
        testsRun++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0ABC) begin
            testsFailed++;
            $display("FAIL reset_first_access: en=%0b we=%0b addr=%h required en=1 we=0 addr=0abc",
                     bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        step(); step(); step();
        $display("[TB] test_reset done");
    endtask

    task automatic test_cpu_load();
        // Preload RAM[0x10] through the arbiter with a store.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010;
        bus.cpu_wdata = 32'hDEADBEEF;
        step();
        idle();
        step(); step(); step();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        #1;
        testsRun++;
        if (bus.cpu_stall !== 1'b0) begin
            testsFailed++;
            $display("FAIL load_stall: got %0b required 0", bus.cpu_stall);
        end
        step();
        idle();
        testsRun++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0010 ||
            bus.cpu_rvalid !== 1'b0) begin
            testsFailed++;
            $display("FAIL load_mem_cycle: en=%0b we=%0b addr=%h rvalid=%0b required 1 0 0010 0",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.cpu_rvalid);
        end
        step();
        testsRun++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF ||
            bus.vga_rvalid !== 1'b0 || bus.mem_en !== 1'b0) begin
            testsFailed++;
            $display("FAIL load_data: rvalid=%0b rdata=%h vrv=%0b en=%0b required 1 deadbeef 0 0",
                     bus.cpu_rvalid, bus.cpu_rdata, bus.vga_rvalid, bus.mem_en);
        end
        step();
        testsRun++;
        if (bus.cpu_rvalid !== 1'b0) begin
            testsFailed++;
            $display("FAIL load_pulse: rvalid=%0b required 0", bus.cpu_rvalid);
        end
        $display("[TB] test_cpu_load done");
    endtask

    task automatic test_starve();
        // Pattern per cycle: 1 = VGA granted and CPU stalled, 0 = CPU goes through.
        logic [9:0] expGnt = 10'b0111101111;   // bit k = cycle k, V V V V C repeating
        int stallCount = 0;
        int errs = 0;
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0030; bus.vga_addr = 16'h0040;
        bus.cpu_req = 1'b1; bus.vga_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (bus.cpu_stall === 1'b1) stallCount++;
            if (bus.vga_gnt !== expGnt[k] || bus.cpu_stall !== expGnt[k]) begin
                errs++;
                $display("FAIL starve_pattern cyc%0d: gnt=%0b stall=%0b required %0b %0b",
                         k, bus.vga_gnt, bus.cpu_stall, expGnt[k], expGnt[k]);
            end
            step();
        end
        testsRun++;
        if (errs != 0) testsFailed++;
        testsRun++;
        if (stallCount != 8) begin
            testsFailed++;
            $display("FAIL starve_stall_count: got %0d required 8", stallCount);
        end
        // Dropping cpu_req clears the starvation count: three VGA wins, a gap,
        // then a full four more VGA wins before the CPU is forced in.
        idle();
        step();
        bus.cpu_req = 1'b1; bus.vga_req = 1'b1;
        step(); step(); step();
        bus.cpu_req = 1'b0;
        step();
        bus.cpu_req = 1'b1;
        errs = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (bus.cpu_stall !== (k < 4)) begin
                errs++;
                $display("FAIL starve_clear cyc%0d: stall=%0b required %0b",
                         k, bus.cpu_stall, (k < 4));
            end
            step();
        end
        testsRun++;
        if (errs != 0) testsFailed++;
        idle();
        step(); step(); step();
        $display("[TB] test_starve done");
    endtask

    task automatic test_back_to_back();
        bus.vga_req = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0020;
        bus.cpu_wdata = 32'h12345678;
        step();
        bus.cpu_we = 1'b0;   // load of the same address accepted the very next edge
        bus.cpu_wdata = 32'h0;
        testsRun++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0020 ||
            bus.mem_wdata !== 32'h12345678) begin
            testsFailed++;
            $display("FAIL b2b_store: en=%0b we=%0b addr=%h wdata=%h required 1 1 0020 12345678",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        step();
        idle();
        testsRun++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
            testsFailed++;
            $display("FAIL b2b_load: en=%0b we=%0b rvalid=%0b required 1 0 0",
                     bus.mem_en, bus.mem_we, bus.cpu_rvalid);
        end
        step();
        testsRun++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h12345678) begin
            testsFailed++;
            $display("FAIL b2b_data: rvalid=%0b rdata=%h required 1 12345678",
                     bus.cpu_rvalid, bus.cpu_rdata);
        end
        step();
        testsRun++;
        if (bus.cpu_rvalid !== 1'b0) begin
            testsFailed++;
            $display("FAIL b2b_single_rvalid: rvalid=%0b required 0", bus.cpu_rvalid);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_reset_mid_read();
        int errs = 0;
        bus.vga_req = 1'b1; bus.vga_addr = 16'h0100;
        step();
        idle();
        reset = 1'b0;
        testsRun++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0100) begin
            testsFailed++;
            $display("FAIL midrst_issue: en=%0b addr=%h required 1 0100",
                     bus.mem_en, bus.mem_addr);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 1) reset = 1'b1;
            if (bus.vga_rvalid !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
                errs++;
                $display("FAIL midrst_ghost cyc%0d: vrv=%0b crv=%0b required 0 0",
                         k, bus.vga_rvalid, bus.cpu_rvalid);
            end
        end
        testsRun++;
        if (errs != 0) testsFailed++;
        $display("[TB] test_reset_mid_read done");
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        reset = 1'b0;
        idle();
        step(); step();
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0030; bus.vga_addr = 16'h0040;
        reset = 1'b1;
        bus.cpu_req = 1'b1; bus.vga_req = 1'b1;
        for (int k = 0; k < 50; k++) step();
        idle();
        testsRun++;
        if (cpuWaitCnt !== 16'd40 || vgaAccCnt !== 16'd40) begin
            testsFailed++;
            $display("FAIL stats_counts: wait=%0d acc=%0d required 40 40",
                     cpuWaitCnt, vgaAccCnt);
        end
        $display("[TB] test_stats done");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.vga_addr = '0;
        test_reset();
        test_cpu_load();
        test_starve();
        test_back_to_back();
        test_reset_mid_read();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
